// File: rtl/pin_entry_collector_pkg.sv
// rtl/pin_entry_collector_pkg.sv - shared state encodings and digit-range limit for PIN entry
package pin_entry_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_SEND    = 2'd3
  } pin_state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/pin_entry_collector_timer.sv
// rtl/pin_entry_collector_timer.sv - saturating idle counter that discards stale partial PINs
module pin_timeout_timer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  // expired flags the last idle cycle so the owner can act on the edge that completes the window
  localparam logic [15:0] LIMIT = (TIMEOUT_CYCLES == 16'd0) ? 16'd0 : TIMEOUT_CYCLES - 16'd1;

  logic [15:0] idle_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (restart || !run) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign expired = run && (idle_cnt >= LIMIT);

endmodule

// File: rtl/pin_entry_collector.sv
// rtl/pin_entry_collector.sv - collects four BCD keypad digits into a PIN code for the gate controller
module pin_entry_collector
  import pin_entry_collector_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter int          NUM_DIGITS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_enter,
  input  logic        key_clear,
  output logic [15:0] code,
  output logic        code_ack,
  output logic [2:0]  digit_count,
  output logic        entry_error,
  output logic        entry_timeout
);

  localparam logic [2:0] FULL_COUNT = 3'(NUM_DIGITS);

  pin_state_t  state, state_nx;
  logic [15:0] code_nx;
  logic [2:0]  count_nx;
  logic        ack_nx, err_nx, to_nx;
  logic        key_evt, run, expired;

  assign key_evt = enable && key_valid && (state != ST_SEND);
  assign run     = enable && ((state == ST_COLLECT) || (state == ST_FULL));

  pin_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .restart(key_evt),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      code          <= '0;
      digit_count   <= '0;
      code_ack      <= 1'b0;
      entry_error   <= 1'b0;
      entry_timeout <= 1'b0;
    end else begin
      state         <= state_nx;
      code          <= code_nx;
      digit_count   <= count_nx;
      code_ack      <= ack_nx;
      entry_error   <= err_nx;
      entry_timeout <= to_nx;
    end
  end

  // key priority is clear > enter > digit; a key in the same cycle as expiry wins
  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = ST_IDLE;
    end else if (state == ST_SEND) begin
      state_nx = ST_IDLE;
    end else if (key_evt) begin
      if (key_clear) begin
        state_nx = ST_IDLE;
      end else if (key_enter) begin
        state_nx = (state == ST_FULL) ? ST_SEND : ST_IDLE;
      end else if (is_bcd(key_digit) && (state != ST_FULL)) begin
        state_nx = ((digit_count + 3'd1) == FULL_COUNT) ? ST_FULL : ST_COLLECT;
      end
    end else if (expired) begin
      state_nx = ST_IDLE;
    end
  end

  always_comb begin
    code_nx  = code;
    count_nx = digit_count;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    to_nx    = 1'b0;
    if (!enable) begin
      code_nx  = '0;
      count_nx = '0;
    end else if (state == ST_SEND) begin
      count_nx = '0;
    end else if (key_evt) begin
      if (key_clear) begin
        code_nx  = '0;
        count_nx = '0;
      end else if (key_enter) begin
        if (state == ST_FULL) begin
          ack_nx = 1'b1;
        end else begin
          err_nx   = 1'b1;
          count_nx = '0;
        end
      end else if (!is_bcd(key_digit) || (state == ST_FULL)) begin
        err_nx = 1'b1;
      end else begin
        code_nx  = {code[11:0], key_digit};
        count_nx = digit_count + 3'd1;
      end
    end else if (expired) begin
      to_nx    = 1'b1;
      code_nx  = '0;
      count_nx = '0;
    end
  end

endmodule

// File: tb/tb_pin_entry_collector.sv
// tb/tb_pin_entry_collector.sv - self-checking bench for pin_entry_collector
module tb_pin_entry_collector;

  localparam logic [15:0] T = 16'd20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_enter = 1'b0;
  logic        key_clear = 1'b0;
  logic [15:0] code;
  logic        code_ack;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        entry_timeout;

  int n_vec = 0;
  int n_err = 0;

  int m_code, m_cnt, m_idle;
  bit m_ack, m_err, m_to, m_send;

  pin_entry_collector #(.TIMEOUT_CYCLES(T), .NUM_DIGITS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .key_enter    (key_enter),
    .key_clear    (key_clear),
    .code         (code),
    .code_ack     (code_ack),
    .digit_count  (digit_count),
    .entry_error  (entry_error),
    .entry_timeout(entry_timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_code = 0; m_cnt = 0; m_idle = 0;
    m_ack = 0; m_err = 0; m_to = 0; m_send = 0;
  endtask

  // reference behaviour: a digit list length, a numeric code and an idle-cycle tally
  task automatic model_step(input bit en, input bit kv, input logic [3:0] d, input bit ent, input bit clr);
    m_ack = 0; m_err = 0; m_to = 0;
    if (!en) begin
      m_code = 0; m_cnt = 0; m_send = 0; m_idle = 0;
    end else if (m_send) begin
      m_send = 0; m_cnt = 0; m_idle = 0;
    end else if (kv) begin
      m_idle = 0;
      if (clr) begin
        m_code = 0; m_cnt = 0;
      end else if (ent) begin
        if (m_cnt == 4) begin m_ack = 1; m_send = 1; end
        else begin m_err = 1; m_cnt = 0; end
      end else if (int'(d) > 9 || m_cnt == 4) begin
        m_err = 1;
      end else begin
        m_code = (m_code * 16 + int'(d)) % 65536;
        m_cnt = m_cnt + 1;
      end
    end else if (m_cnt > 0) begin
      m_idle = m_idle + 1;
      if (m_idle >= int'(T)) begin
        m_to = 1; m_code = 0; m_cnt = 0; m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic apply(input bit en, input bit kv, input logic [3:0] d, input bit ent, input bit clr);
    @(negedge clk);
    enable = en; key_valid = kv; key_digit = d; key_enter = ent; key_clear = clr;
    @(posedge clk);
    model_step(en, kv, d, ent, clr);
    #1;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    apply(1, 1, d, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 4'd0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({code, digit_count, code_ack, entry_error, entry_timeout} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs got code=%h cnt=%0d ack=%b err=%b to=%b want all 0",
               code, digit_count, code_ack, entry_error, entry_timeout);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_full_entry();
    press(2); press(4); press(6); press(8);
    n_vec++;
    if (code !== 16'h2468 || digit_count !== 3'd4 || code_ack !== 1'b0) begin
      n_err++;
      $display("FAIL full_collect got code=%h cnt=%0d ack=%b want 2468 4 0", code, digit_count, code_ack);
    end
    apply(1, 1, 4'd0, 1, 0);
    n_vec++;
    if (code_ack !== 1'b1 || code !== 16'h2468) begin
      n_err++;
      $display("FAIL full_ack got ack=%b code=%h want 1 2468", code_ack, code);
    end
    idle(1);
    n_vec++;
    if (code_ack !== 1'b0 || digit_count !== 3'd0 || code !== 16'h2468) begin
      n_err++;
      $display("FAIL full_after got ack=%b cnt=%0d code=%h want 0 0 2468", code_ack, digit_count, code);
    end
  endtask

  task automatic test_short_enter();
    press(1); press(2);
    apply(1, 1, 4'd0, 1, 0);
    n_vec++;
    if (entry_error !== 1'b1 || code_ack !== 1'b0 || digit_count !== 3'd0) begin
      n_err++;
      $display("FAIL short_enter got err=%b ack=%b cnt=%0d want 1 0 0", entry_error, code_ack, digit_count);
    end
    idle(1);
    n_vec++;
    if (entry_error !== 1'b0) begin
      n_err++;
      $display("FAIL short_err_pulse got err=%b want 0", entry_error);
    end
  endtask

  task automatic test_illegal_digit();
    apply(1, 1, 4'd0, 0, 1);
    press(4'hA);
    n_vec++;
    if (entry_error !== 1'b1 || digit_count !== 3'd0 || code !== 16'h0000) begin
      n_err++;
      $display("FAIL illegal_a got err=%b cnt=%0d code=%h want 1 0 0000", entry_error, digit_count, code);
    end
    press(1); press(2); press(3); press(4);
    n_vec++;
    if (entry_error !== 1'b0 || code !== 16'h1234 || digit_count !== 3'd4) begin
      n_err++;
      $display("FAIL illegal_four got err=%b code=%h cnt=%0d want 0 1234 4", entry_error, code, digit_count);
    end
    press(5);
    n_vec++;
    if (entry_error !== 1'b1 || code !== 16'h1234 || digit_count !== 3'd4) begin
      n_err++;
      $display("FAIL illegal_fifth got err=%b code=%h cnt=%0d want 1 1234 4", entry_error, code, digit_count);
    end
    apply(1, 1, 4'd0, 0, 1);
  endtask

  task automatic test_timeout();
    press(7);
    idle(int'(T) - 1);
    n_vec++;
    if (entry_timeout !== 1'b0 || code !== 16'h0007 || digit_count !== 3'd1) begin
      n_err++;
      $display("FAIL timeout_early got to=%b code=%h cnt=%0d want 0 0007 1", entry_timeout, code, digit_count);
    end
    idle(1);
    n_vec++;
    if (entry_timeout !== 1'b1 || code !== 16'h0000 || digit_count !== 3'd0) begin
      n_err++;
      $display("FAIL timeout_fire got to=%b code=%h cnt=%0d want 1 0000 0", entry_timeout, code, digit_count);
    end
    idle(1);
    n_vec++;
    if (entry_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse got to=%b want 0", entry_timeout);
    end
    press(7);
    idle(int'(T) - 2);
    press(3);
    idle(int'(T) - 1);
    n_vec++;
    if (entry_timeout !== 1'b0 || code !== 16'h0073 || digit_count !== 3'd2) begin
      n_err++;
      $display("FAIL timeout_restart got to=%b code=%h cnt=%0d want 0 0073 2", entry_timeout, code, digit_count);
    end
    idle(1);
    n_vec++;
    if (entry_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_restart_fire got to=%b want 1", entry_timeout);
    end
  endtask

  task automatic test_clear_enter();
    press(1); press(2); press(3); press(4);
    apply(1, 1, 4'd0, 1, 1);
    n_vec++;
    if (digit_count !== 3'd0 || code !== 16'h0000 || code_ack !== 1'b0 || entry_error !== 1'b0) begin
      n_err++;
      $display("FAIL clear_enter got cnt=%0d code=%h ack=%b err=%b want 0 0000 0 0",
               digit_count, code, code_ack, entry_error);
    end
    idle(1);
    n_vec++;
    if (code_ack !== 1'b0 || entry_error !== 1'b0) begin
      n_err++;
      $display("FAIL clear_enter_after got ack=%b err=%b want 0 0", code_ack, entry_error);
    end
  endtask

  task automatic test_enable_drop();
    press(9); press(8); press(7); press(6);
    apply(0, 0, 4'd0, 0, 0);
    n_vec++;
    if ({code, digit_count, code_ack, entry_error, entry_timeout} !== 22'd0) begin
      n_err++;
      $display("FAIL enable_drop got code=%h cnt=%0d ack=%b err=%b to=%b want all 0",
               code, digit_count, code_ack, entry_error, entry_timeout);
    end
    apply(0, 1, 4'd5, 0, 0);
    n_vec++;
    if (digit_count !== 3'd0 || code !== 16'h0000) begin
      n_err++;
      $display("FAIL enable_low_key got cnt=%0d code=%h want 0 0000", digit_count, code);
    end
    press(1); press(3); press(5); press(7);
    apply(1, 1, 4'd0, 1, 0);
    n_vec++;
    if (code_ack !== 1'b1 || code !== 16'h1357) begin
      n_err++;
      $display("FAIL enable_recover got ack=%b code=%h want 1 1357", code_ack, code);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    press(1); press(2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({code, digit_count, code_ack, entry_error, entry_timeout} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_mid got code=%h cnt=%0d ack=%b err=%b to=%b want all 0",
               code, digit_count, code_ack, entry_error, entry_timeout);
    end
    rst = 1'b1;
    model_reset();
    press(4); press(3); press(2); press(1);
    apply(1, 1, 4'd0, 1, 0);
    n_vec++;
    if (code_ack !== 1'b1 || code !== 16'h4321) begin
      n_err++;
      $display("FAIL reset_recover got ack=%b code=%h want 1 4321", code_ack, code);
    end
    idle(1);
  endtask

  task automatic test_random();
    bit en, kv, ent, clr;
    logic [3:0] d;
    for (int i = 0; i < 900; i++) begin
      en  = ($urandom_range(0, 49) != 0);
      kv  = ($urandom_range(0, 1) == 1);
      d   = 4'($urandom_range(0, 11));
      ent = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 24) == 0);
      if ((i % 150) >= 120) begin
        en = 1; kv = 0;
      end
      apply(en, kv, d, ent, clr);
      n_vec++;
      if (code !== m_code[15:0] || digit_count !== 3'(m_cnt) || code_ack !== m_ack ||
          entry_error !== m_err || entry_timeout !== m_to) begin
        n_err++;
        $display("FAIL random[%0d] got code=%h cnt=%0d ack=%b err=%b to=%b want %h %0d %b %b %b",
                 i, code, digit_count, code_ack, entry_error, entry_timeout,
                 m_code[15:0], m_cnt, m_ack, m_err, m_to);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_entry();
    test_short_enter();
    test_illegal_digit();
    test_timeout();
    test_clear_enter();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
